pico_receiver: RTL and testbench

- Controller-in serial receiver: the input-side counterpart of the POCI readout path.
- Deserializes LSB-first frames from the controller on sclk: an 8-bit address, then an 8-bit data byte for writable addresses.
- Drives the register-select bus (control_signal) and the write path (write_data, wr_en) that feed the POCI block.
- Flags out-of-map addresses.

---
 rtl/regmap_pkg.sv | 11 +
 rtl/pico_receiver_if.sv | 22 ++
 rtl/s2p_register.sv | 32 +++
 rtl/pico_receiver.sv | 74 +++++++
 tb/tb_pico_receiver.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/regmap_pkg.sv
// regmap_pkg: register map constants and receiver FSM state type shared by the
// POCI/PICO serial blocks.
package regmap_pkg;
   localparam int ADDR_RESERVED    = 0;
   localparam int ADDR_TRIG_MASK   = 1;
   localparam int ADDR_INSTRUCTION = 2;
   localparam int ADDR_MODE        = 3;
   localparam int NUM_REGS         = 59;
   localparam int NUM_WR_REGS      = 3;
   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} pico_state_t;
endpackage

// File: rtl/pico_receiver_if.sv
// pico_receiver_if: controller-in serial pins plus the register-select/write
// bus feeding the POCI block.
interface pico_receiver_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              csn;
   logic              serial_in;
   logic [ADDR_W-1:0] control_signal;
   logic [DATA_W-1:0] write_data;
   logic              wr_en;
   logic              addr_err;
   logic              busy;
   modport master (
      output csn, serial_in,
      input  control_signal, write_data, wr_en, addr_err, busy
   );
   modport slave (
      input  csn, serial_in,
      output control_signal, write_data, wr_en, addr_err, busy
   );
endinterface

// File: rtl/s2p_register.sv
// s2p_register: LSB-first serial-to-parallel shifter with a wrapping bit counter;
// word presents the byte including the bit arriving on the current edge.
module s2p_register #(
   parameter int W = 8
) (
   input  logic         sclk,
   input  logic         rstn,
   input  logic         shift_en,
   input  logic         clear,
   input  logic         serial_in,
   output logic [W-1:0] word,
   output logic         byte_done
);
   localparam int CW = $clog2(W);
   logic [W-1:0]  shreg;
   logic [CW-1:0] cnt;
   always_ff @(posedge sclk or negedge rstn)
      if (!rstn) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (clear) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (shift_en) begin
         shreg <= word;
         cnt   <= cnt + CW'(1);
      end
   assign word      = {serial_in, shreg[W-1:1]};
   assign byte_done = shift_en && !clear && cnt == CW'(W-1);
   // the oldest bit is always shifted out before a byte completes
   wire unused_lsb = shreg[0];
endmodule

// File: rtl/pico_receiver.sv
// pico_receiver: deserializes address/data frames from the controller and drives
// the register-select and write path of the POCI block.
module pico_receiver #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int NUM_REGS    = regmap_pkg::NUM_REGS,
   parameter int NUM_WR_REGS = regmap_pkg::NUM_WR_REGS
) (
   input logic             sclk,
   input logic             rstn,
   pico_receiver_if.slave  bus
);
   import regmap_pkg::*;
   pico_state_t       state_q, state_d;
   logic [DATA_W-1:0] word;
   logic [ADDR_W-1:0] addr, cs_d;
   logic [DATA_W-1:0] wd_d;
   logic              byte_done, shift_en, wr_d, err_d, in_map, writable;
   // csn high at any edge drops a partial field, including one that would complete
   assign shift_en = !bus.csn && state_q != DONE;
   s2p_register #(.W(DATA_W)) u_s2p (
      .sclk      (sclk),
      .rstn      (rstn),
      .shift_en  (shift_en),
      .clear     (bus.csn),
      .serial_in (bus.serial_in),
      .word      (word),
      .byte_done (byte_done)
   );
   assign addr     = ADDR_W'(word);
   assign in_map   = addr != '0 && addr <= ADDR_W'(NUM_REGS);
   assign writable = addr != '0 && addr <= ADDR_W'(NUM_WR_REGS);
   always_comb begin
      state_d = state_q;
      cs_d    = bus.control_signal;
      wd_d    = bus.write_data;
      err_d   = bus.addr_err;
      wr_d    = 1'b0;
      case (state_q)
         IDLE: state_d = bus.csn ? IDLE : ADDR;
         ADDR:
            if (bus.csn) state_d = IDLE;
            else if (byte_done) begin
               cs_d    = in_map ? addr : '0;
               err_d   = !in_map;
               state_d = writable ? DATA : DONE;
            end
         DATA:
            if (bus.csn) state_d = IDLE;
            else if (byte_done) begin
               wd_d    = word;
               wr_d    = 1'b1;
               state_d = DONE;
            end
         DONE:    state_d = bus.csn ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge sclk or negedge rstn)
      if (!rstn) begin
         state_q            <= IDLE;
         bus.control_signal <= '0;
         bus.write_data     <= '0;
         bus.wr_en          <= 1'b0;
         bus.addr_err       <= 1'b0;
      end else begin
         state_q            <= state_d;
         bus.control_signal <= cs_d;
         bus.write_data     <= wd_d;
         bus.wr_en          <= wr_d;
         bus.addr_err       <= err_d;
      end
   assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_pico_receiver.sv
// tb_pico_receiver: scenario tasks for pico_receiver with a write scoreboard
// checked on every wr_en pulse.
module tb_pico_receiver;
   logic sclk = 1'b0;
   logic rstn;
   int tests = 0;
   int fails = 0;
   int wr_seen = 0;
   logic [15:0] exp_q[$];
   logic [15:0] mon_exp;
   pico_receiver_if bus ();
   pico_receiver dut (.sclk(sclk), .rstn(rstn), .bus(bus));
   always #5 sclk = ~sclk;
   always @(negedge sclk)
      if (rstn === 1'b1 && bus.wr_en === 1'b1) begin
         tests++;
         wr_seen++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL wr_pulse: unexpected write addr=%0d data=%h", bus.control_signal, bus.write_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({bus.control_signal, bus.write_data} !== mon_exp) begin
               fails++;
               $display("FAIL wr_pulse: got addr=%0d data=%h expected addr=%0d data=%h",
                        bus.control_signal, bus.write_data, mon_exp[15:8], mon_exp[7:0]);
            end
         end
      end
   task automatic send_bit(input logic b);
      @(negedge sclk);
      bus.csn = 1'b0;
      bus.serial_in = b;
      @(posedge sclk);
      #1;
   endtask
   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
   endtask
   task automatic end_frame();
      @(negedge sclk);
      bus.csn = 1'b1;
      bus.serial_in = 1'b0;
      @(posedge sclk);
      #1;
   endtask
   task automatic write_frame(input logic [7:0] a, input logic [7:0] d);
      exp_q.push_back({a, d});
      send_byte(a);
      send_byte(d);
      end_frame();
   endtask
   task automatic test_reset();
      rstn = 1'b0;
      bus.csn = 1'b1;
      bus.serial_in = 1'b0;
      repeat (2) @(negedge sclk);
      tests++;
      if ({bus.control_signal, bus.write_data, bus.wr_en, bus.addr_err, bus.busy} !== 19'd0) begin
         fails++;
         $display("FAIL reset: cs=%0d wd=%h wr=%b err=%b busy=%b expected all 0",
                  bus.control_signal, bus.write_data, bus.wr_en, bus.addr_err, bus.busy);
      end
      rstn = 1'b1;
   endtask
   task automatic test_write();
      exp_q.push_back({8'h02, 8'hA5});
      send_byte(8'h02);
      tests++;
      if (bus.control_signal !== 8'd2 || bus.addr_err !== 1'b0 || bus.busy !== 1'b1) begin
         fails++;
         $display("FAIL write_addr: cs=%0d err=%b busy=%b expected 2 0 1", bus.control_signal, bus.addr_err, bus.busy);
      end
      send_byte(8'hA5);
      tests++;
      if (bus.wr_en !== 1'b1 || bus.write_data !== 8'hA5) begin
         fails++;
         $display("FAIL write_pulse: wr=%b wd=%h expected 1 a5", bus.wr_en, bus.write_data);
      end
      end_frame();
      tests++;
      if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL write_end: wr=%b busy=%b expected 0 0", bus.wr_en, bus.busy);
      end
   endtask
   task automatic test_read();
      int w = wr_seen;
      send_byte(8'h11);
      tests++;
      if (bus.control_signal !== 8'd17 || bus.addr_err !== 1'b0) begin
         fails++;
         $display("FAIL read_addr: cs=%0d err=%b expected 17 0", bus.control_signal, bus.addr_err);
      end
      send_byte(8'hFF);
      tests++;
      if (bus.busy !== 1'b1 || wr_seen != w || bus.control_signal !== 8'd17) begin
         fails++;
         $display("FAIL read_done: busy=%b writes=%0d cs=%0d expected 1 %0d 17", bus.busy, wr_seen, bus.control_signal, w);
      end
      end_frame();
      tests++;
      if (bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL read_idle: busy=%b expected 0", bus.busy);
      end
   endtask
   task automatic test_invalid();
      int w = wr_seen;
      send_byte(8'h3C);
      tests++;
      if (bus.control_signal !== 8'd0 || bus.addr_err !== 1'b1) begin
         fails++;
         $display("FAIL addr_60: cs=%0d err=%b expected 0 1", bus.control_signal, bus.addr_err);
      end
      end_frame();
      send_byte(8'h3B);
      tests++;
      if (bus.control_signal !== 8'd59 || bus.addr_err !== 1'b0) begin
         fails++;
         $display("FAIL addr_59: cs=%0d err=%b expected 59 0", bus.control_signal, bus.addr_err);
      end
      end_frame();
      send_byte(8'h00);
      tests++;
      if (bus.control_signal !== 8'd0 || bus.addr_err !== 1'b1) begin
         fails++;
         $display("FAIL addr_0: cs=%0d err=%b expected 0 1", bus.control_signal, bus.addr_err);
      end
      end_frame();
      send_byte(8'h05);
      tests++;
      if (bus.control_signal !== 8'd5 || bus.addr_err !== 1'b0 || wr_seen != w) begin
         fails++;
         $display("FAIL addr_5: cs=%0d err=%b writes=%0d expected 5 0 %0d", bus.control_signal, bus.addr_err, wr_seen, w);
      end
      end_frame();
   endtask
   task automatic test_abort();
      int w = wr_seen;
      send_byte(8'h03);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      end_frame();
      tests++;
      if (bus.busy !== 1'b0 || bus.write_data !== 8'hA5 || bus.control_signal !== 8'd3 || wr_seen != w) begin
         fails++;
         $display("FAIL abort: busy=%b wd=%h cs=%0d writes=%0d expected 0 a5 3 %0d",
                  bus.busy, bus.write_data, bus.control_signal, wr_seen, w);
      end
      write_frame(8'h03, 8'h0F);
      tests++;
      if (bus.write_data !== 8'h0F || wr_seen != w + 1) begin
         fails++;
         $display("FAIL abort_retry: wd=%h writes=%0d expected 0f %0d", bus.write_data, wr_seen, w + 1);
      end
      for (int i = 0; i < 7; i++) send_bit(i == 0 || i == 2);
      end_frame();
      tests++;
      if (bus.control_signal !== 8'd3 || bus.addr_err !== 1'b0 || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL abort_edge: cs=%0d err=%b busy=%b expected 3 0 0", bus.control_signal, bus.addr_err, bus.busy);
      end
   endtask
   task automatic test_reset_mid();
      int w = wr_seen;
      send_byte(8'h01);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      bus.csn = 1'b1;
      rstn = 1'b0;
      #1;
      tests++;
      if ({bus.control_signal, bus.write_data, bus.wr_en, bus.addr_err, bus.busy} !== 19'd0) begin
         fails++;
         $display("FAIL reset_mid: cs=%0d wd=%h wr=%b err=%b busy=%b expected all 0",
                  bus.control_signal, bus.write_data, bus.wr_en, bus.addr_err, bus.busy);
      end
      repeat (2) @(negedge sclk);
      rstn = 1'b1;
      repeat (4) @(posedge sclk);
      #1;
      tests++;
      if (wr_seen != w || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: writes=%0d busy=%b expected %0d 0", wr_seen, bus.busy, w);
      end
      write_frame(8'h01, 8'h3C);
      tests++;
      if (bus.control_signal !== 8'd1 || bus.write_data !== 8'h3C) begin
         fails++;
         $display("FAIL reset_new_frame: cs=%0d wd=%h expected 1 3c", bus.control_signal, bus.write_data);
      end
   endtask
   task automatic test_back_to_back();
      int w = wr_seen;
      write_frame(8'h01, 8'hFF);
      write_frame(8'h02, 8'h81);
      tests++;
      if (wr_seen != w + 2 || bus.control_signal !== 8'd2 || bus.write_data !== 8'h81) begin
         fails++;
         $display("FAIL back_to_back: writes=%0d cs=%0d wd=%h expected %0d 2 81",
                  wr_seen - w, bus.control_signal, bus.write_data, 2);
      end
   endtask
   initial begin
      test_reset();
      test_write();
      test_read();
      test_invalid();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      repeat (3) @(negedge sclk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d writes pending expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
